arbitro_enrutamiento_n: RTL

ARBITRO_ENRUTAMIENTO_N -- requirements
Module: arbitro_enrutamiento_n

---
 rtl/arbitro_enrutamiento_n.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arbitro_enrutamiento_n.sv
// rtl/arbitro_enrutamiento_n.sv - VC-to-destination arbiter/router with per-destination back-pressure
// Optional per-VC saturating grant counters are enabled by defining ARBITRO_CNT_EN.
module arbitro_enrutamiento_n #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int DEST_LSB = 4,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_VC*DATA_W-1:0]   vc_data,
  input  logic [NUM_VC-1:0]          vc_empty,
  input  logic [NUM_DEST-1:0]        d_pause,
  output logic [NUM_VC-1:0]          vc_pop,
  output logic [NUM_DEST-1:0]        d_push,
  output logic [NUM_DEST*DATA_W-1:0] d_data
`ifdef ARBITRO_CNT_EN
  ,
  output logic [NUM_VC*CNT_W-1:0]    grant_cnt
`endif
);

  localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 0;
  localparam int SEL_W  = (DEST_W > 0) ? DEST_W : 1;
  localparam int PTR_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [DATA_W-1:0] head      [NUM_VC];
  logic [SEL_W-1:0]  head_dest [NUM_VC];
  logic [NUM_VC-1:0] eligible;

  // Each VC is judged only against its own head's destination, so a paused lane never blocks others.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign head[i] = vc_data[i*DATA_W +: DATA_W];
    if (DEST_W > 0) begin : g_dest
      assign head_dest[i] = head[i][DEST_LSB +: SEL_W];
    end else begin : g_nodest
      assign head_dest[i] = '0;
    end
    assign eligible[i] = !vc_empty[i] && !d_pause[head_dest[i]] && !reset;
  end

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_dest;
  logic [DATA_W-1:0] grant_word;

  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_VC-1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_idx = PTR_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Scan backwards so the eligible VC nearest rr_ptr is the last one written.
      for (int k = NUM_VC-1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_VC;
        if (eligible[idx]) begin
          grant_idx = PTR_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    vc_pop = '0;
    if (grant_vld) vc_pop[grant_idx] = 1'b1;
  end

  assign grant_dest = head_dest[grant_idx];
  assign grant_word = head[grant_idx];

  logic [NUM_DEST-1:0] d_push_q, d_push_d;
  logic [DATA_W-1:0]   d_data_q [NUM_DEST];
  logic [DATA_W-1:0]   d_data_d [NUM_DEST];

  always_comb begin
    d_push_d = '0;
    rr_ptr_d = rr_ptr_q;
    for (int j = 0; j < NUM_DEST; j++) begin
      d_data_d[j] = d_data_q[j];
      if (grant_vld && (int'(grant_dest) == j)) begin
        d_push_d[j] = 1'b1;
        d_data_d[j] = grant_word;
      end
    end
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_VC-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_push_q <= '0;
      rr_ptr_q <= '0;
      for (int j = 0; j < NUM_DEST; j++) d_data_q[j] <= '0;
    end else begin
      d_push_q <= d_push_d;
      rr_ptr_q <= rr_ptr_d;
      for (int j = 0; j < NUM_DEST; j++) d_data_q[j] <= d_data_d[j];
    end
  end

  assign d_push = d_push_q;
  for (genvar j = 0; j < NUM_DEST; j++) begin : g_lane
    assign d_data[j*DATA_W +: DATA_W] = d_data_q[j];
  end

`ifdef ARBITRO_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_VC];
  logic [CNT_W-1:0] cnt_d [NUM_VC];

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (vc_pop[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_cnt
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
